// File: rtl/icu_sequencer.sv
// Instruction-side sequencer for the ICU: program counter, return-address stack and word split.
// Define ICU_SEQ_HALT_EN to build the RUN/HALT FSM driven by flag_o (halt) and run (resume).
module icu_sequencer #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [OP_W+ADDR_W-1:0]       mem_data,
  output logic [OP_W-1:0]              instr,
  output logic [ADDR_W-1:0]            io_addr,
  input  logic                         jmp,
  input  logic                         rtn,
  input  logic                         flag_f,
  input  logic                         flag_o,
  input  logic                         run,
  output logic                         halted,
  output logic                         stack_err,
  output logic [$clog2(DEPTH+1)-1:0]   sp
);

  localparam int SP_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_n;
  logic              call_armed;
  logic              push;
  logic              err_set;
  logic              halt_req;
  logic              resume;

  // The ICU latched this word at the previous negedge, so its operand is the jump target now.
  assign mem_addr = pc;
  assign instr    = mem_data[OP_W+ADDR_W-1:ADDR_W];
  assign operand  = mem_data[ADDR_W-1:0];
  assign io_addr  = operand;
  assign sp       = sp_q;

`ifdef ICU_SEQ_HALT_EN
  assign halt_req = flag_o;
  assign resume   = run;
  assign halted   = (state == ST_HALT);
`else
  logic unused_halt_ctrl;
  assign unused_halt_ctrl = flag_o ^ run;
  assign halt_req = 1'b0;
  assign resume   = 1'b0;
  assign halted   = 1'b0;
`endif

  // Entry sp-1 holds the most recent return address.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) stack_top = stack_mem[i];
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    sp_n    = sp_q;
    push    = 1'b0;
    err_set = 1'b0;
    if (state == ST_RUN) begin
      if (rtn) begin
        if (sp_q == '0) begin
          pc_n    = '0;
          err_set = 1'b1;
        end else begin
          pc_n = stack_top;
          sp_n = sp_q - SP_W'(1);
        end
      end else if (jmp) begin
        pc_n = operand;
        if (call_armed) begin
          // A full stack drops the return address but the jump itself still happens.
          if (sp_q == SP_W'(DEPTH)) begin
            err_set = 1'b1;
          end else begin
            push = 1'b1;
            sp_n = sp_q + SP_W'(1);
          end
        end
      end else if (halt_req) begin
        state_n = ST_HALT;
      end else begin
        pc_n = pc + ADDR_W'(1);
      end
    end else begin
      if (resume) begin
        pc_n    = pc + ADDR_W'(1);
        state_n = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      pc         <= '0;
      sp_q       <= '0;
      call_armed <= 1'b0;
      stack_err  <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      sp_q       <= sp_n;
      call_armed <= flag_f;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Pushed value is the JMP's own address; RTN lands there and the ICU skips it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst && push && (sp_q == SP_W'(i))) stack_mem[i] <= pc;
    end
  end

endmodule
